single_port_ram_ctrl: RTL
=========================

# single_port_ram_ctrl

Bus initiator for `single_port_ram`. It accepts burst read/write commands from a host over valid/ready handshakes and drives the RAM's `addr`, `cs`, `wr`, `oe` pins and bidirectional `data` bus. It captures read data after the RAM's negedge output update and guarantees the shared data bus is never driven by both ends at once. It sits between any host engine and one `single_port_ram` instance.

## Interface
Parameters:
- ADDR_WIDTH, 4, RAM address width
- DATA_WIDTH, 16, word width
- DEPTH, 16, number of words (≤ 2^ADDR_WIDTH); addresses wrap at DEPTH
- LEN_WIDTH, 4, burst length field width; a burst is req_len+1 beats

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid&ready
- req_wr  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  start address (< DEPTH)
- req_len  in  LEN_WIDTH  beats minus one
- wdata_valid  in  1  write beat valid
- wdata_ready  out  1  write beat accepted when valid&ready
- wdata  in  DATA_WIDTH  write beat data
- wr_done  out  1  one-cycle pulse, last write beat committed
- rsp_valid  out  1  read beat valid
- rsp_ready  in  1  host accepts read beat
- rsp_rdata  out  DATA_WIDTH  read beat data
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_cs / ram_wr / ram_oe  out  1 each  to RAM cs/wr/oe
- ram_data  inout  DATA_WIDTH  to RAM data; driven only when ram_cs&ram_wr, else Z

## Operation
- FSM states: IDLE, WR, RD, RWAIT. All RAM-side outputs are registered.
- IDLE: req_ready=1. On accept, latch cur_addr=req_addr and beats=req_len. Go to WR if req_wr, else RD.
- WR: wdata_ready=1. Each handshake registers ram_cs=1, ram_wr=1, ram_oe=0, ram_addr=cur_addr and the drive data. The RAM commits the word on the next posedge.
  - Cycles without a handshake register ram_cs=0.
  - On the last-beat handshake go to IDLE; wr_done pulses in the following cycle, the same cycle the RAM commits.
- RD: registers ram_cs=1, ram_wr=0, ram_oe=1, ram_addr=cur_addr for one cycle. The RAM updates data on that cycle's negedge; the controller samples ram_data at the next posedge into rsp_rdata, sets rsp_valid=1, and goes to RWAIT.
- RWAIT: ram_cs=0, so the bus is released. Stay while rsp_valid&!rsp_ready. On accept, clear rsp_valid; go to RD if beats remain, else IDLE. RWAIT doubles as the bus turnaround, so a write can never follow a read in the next cycle.
- Address: after each beat, cur_addr = (cur_addr==DEPTH-1) ? 0 : cur_addr+1. The beat counter decrements per beat.
- Write-beat data is ignored outside WR. Commands are never accepted outside IDLE.

## Timing
- Reset values: state=IDLE; req_ready=1; wdata_ready=0; wr_done=0; rsp_valid=0; rsp_rdata=0; ram_cs=ram_wr=ram_oe=0; ram_addr=0; ram_data=Z.
- Write: the first beat can be handshaken the cycle after command accept; sustained throughput is 1 beat/cycle.
- Read: first rsp_valid comes 2 cycles after command accept. Throughput is 1 beat per 2 cycles with rsp_ready held high.
- rsp_rdata is stable while rsp_valid&!rsp_ready.
- Reset mid-burst: everything returns to reset values immediately (asynchronous); the remaining beats are dropped and the bus is released.
- A write command accepted in the cycle when the previous write's final RAM commit is in flight is legal; no overlap is possible.

## Structure
- Shared package: FSM state enum and the `next_addr` wrap function, parameterised by DEPTH.
- The tristate driver is one assign in the top. No sub-module is needed beyond an optional `ram_bus_if` holding the output registers and tristate.

## Test plan
- Reset, then a 1-beat write of 0xBEEF to addr 3, then a 1-beat read of addr 3 → wr_done pulses once; rsp_rdata=0xBEEF 2 cycles after read accept.
- 4-beat write from addr 14, DEPTH=16, data 0x0001..0x0004 → RAM words 14, 15, 0, 1 hold those values; a 4-beat read returns them in order.
- Read burst with rsp_ready low for 5 cycles on beat 2 → rsp_rdata held; ram_cs stays 0 during the stall; no beat lost or duplicated.
- wdata_valid gaps mid-burst → ram_cs=0 in gap cycles; only handshaken beats are written, at consecutive addresses.
- Read immediately followed by a write command → ram_data is never driven by the controller while ram_oe=1 (checked by an X/contention assertion).
- rst asserted mid-read burst → all outputs at reset values in the same cycle; a subsequent command executes normally.

Source files
------------

// File: rtl/single_port_ram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// single_port_ram_ctrl_pkg
// Shared definitions for the single-port RAM bus initiator.
//   state_t   : controller FSM state encoding (IDLE, WR, RD, RWAIT)
//   next_addr : wrapping address increment, wraps to 0 after depth-1
// -----------------------------------------------------------------------------
package single_port_ram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR    = 2'd1,
      ST_RD    = 2'd2,
      ST_RWAIT = 2'd3
   } state_t;

   // Address after addr in a RAM of 'depth' words; depth need not be a
   // power of two, so the wrap is an explicit compare rather than overflow.
   function automatic int unsigned next_addr(input int unsigned addr,
                                             input int unsigned depth);
      return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
   endfunction

endpackage

// File: rtl/single_port_ram_ctrl.sv
// -----------------------------------------------------------------------------
// single_port_ram_ctrl
// Bus initiator for one single_port_ram. Accepts burst read/write commands
// from a host and drives the RAM pins, capturing read data one posedge after
// the RAM's negedge output update.
//
// Handshakes: a transfer on any channel (req, wdata, rsp) happens on a rising
// clk edge where that channel's valid and ready are both high; the producer
// holds its payload stable while valid is high and ready is low.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         command channel; req_wr, req_addr, req_len
//                               (burst of req_len+1 beats)
//   wdata_valid/wdata_ready     write-beat channel; wdata
//   wr_done                     one-cycle pulse while the final write commits
//   rsp_valid/rsp_ready         read-beat channel; rsp_rdata
//   ram_addr, ram_cs, ram_wr,   registered RAM control outputs
//   ram_oe
//   ram_data                    shared bus, driven only while ram_cs&ram_wr
//
// The internal 'state' register (state_t) is the FSM state for observation.
// -----------------------------------------------------------------------------
module single_port_ram_ctrl
   import single_port_ram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  wr_done,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_cs,
   output logic                  ram_wr,
   output logic                  ram_oe,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;   // address of the next beat to issue
   logic [LEN_WIDTH-1:0]  beats;      // beats remaining after the current one
   logic [DATA_WIDTH-1:0] wdata_q;    // registered drive data for ram_data

   function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] a);
      return ADDR_WIDTH'(next_addr(32'(a), DEPTH));
   endfunction

   // Controller drives the bus only during a registered write cycle; the RAM
   // drives it only while ram_wr is low, so the two can never overlap.
   assign ram_data = (ram_cs && ram_wr) ? wdata_q : {DATA_WIDTH{1'bz}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cur_addr    <= '0;
         beats       <= '0;
         wdata_q     <= '0;
         req_ready   <= 1'b1;
         wdata_ready <= 1'b0;
         wr_done     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         ram_addr    <= '0;
         ram_cs      <= 1'b0;
         ram_wr      <= 1'b0;
         ram_oe      <= 1'b0;
      end else begin
         wr_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               ram_cs <= 1'b0;
               ram_wr <= 1'b0;
               ram_oe <= 1'b0;
               if (req_valid) begin
                  req_ready <= 1'b0;
                  beats     <= req_len;
                  if (req_wr) begin
                     state       <= ST_WR;
                     wdata_ready <= 1'b1;
                     cur_addr    <= req_addr;
                  end else begin
                     // The first read cycle is issued straight from the
                     // accept edge, so RD is always a cycle with ram_cs high.
                     state    <= ST_RD;
                     ram_cs   <= 1'b1;
                     ram_oe   <= 1'b1;
                     ram_addr <= req_addr;
                     cur_addr <= bump(req_addr);
                  end
               end
            end

            ST_WR: begin
               ram_cs <= 1'b0;
               ram_wr <= 1'b0;
               ram_oe <= 1'b0;
               if (wdata_valid) begin
                  ram_cs   <= 1'b1;
                  ram_wr   <= 1'b1;
                  ram_addr <= cur_addr;
                  wdata_q  <= wdata;
                  cur_addr <= bump(cur_addr);
                  if (beats == '0) begin
                     // wr_done lands in the cycle the RAM commits this beat.
                     state       <= ST_IDLE;
                     wdata_ready <= 1'b0;
                     req_ready   <= 1'b1;
                     wr_done     <= 1'b1;
                  end else begin
                     beats <= beats - LEN_WIDTH'(1);
                  end
               end
            end

            ST_RD: begin
               // RAM updated ram_data on the negedge of this cycle.
               rsp_rdata <= ram_data;
               rsp_valid <= 1'b1;
               ram_cs    <= 1'b0;
               ram_oe    <= 1'b0;
               state     <= ST_RWAIT;
            end

            ST_RWAIT: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (beats != '0) begin
                     beats    <= beats - LEN_WIDTH'(1);
                     state    <= ST_RD;
                     ram_cs   <= 1'b1;
                     ram_oe   <= 1'b1;
                     ram_addr <= cur_addr;
                     cur_addr <= bump(cur_addr);
                  end else begin
                     state     <= ST_IDLE;
                     req_ready <= 1'b1;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
